// File: rtl/bp_fe_bp_update_tracker.sv
// In-flight branch prediction queue that emits bimodal BHT updates on resolve.
// Optional stat counters: BP_FE_BP_UPDATE_TRACKER_STATS_EN.
module bp_fe_bp_update_tracker #(
  parameter int bht_idx_width_p = 8,
  parameter int els_p = 8,
  localparam int ptr_width_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_width_lp:0]      count_o,
  output logic                       res_err_o,
  output logic [31:0]                mispred_cnt_o,
  output logic [31:0]                update_cnt_o
);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       taken;
  } entry_t;

  localparam logic [ptr_width_lp-1:0] ptr_one_lp = 1;
  localparam logic [ptr_width_lp:0] cnt_one_lp = 1;
  localparam logic [ptr_width_lp:0] cnt_full_lp = els_p;

  entry_t                  mem [els_p];
  entry_t                  head_e;
  logic [ptr_width_lp-1:0] head, tail;
  logic [ptr_width_lp:0]   count;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    hit;

  assign empty        = (count == '0);
  assign pred_ready_o = (count != cnt_full_lp) & ~flush_i;
  assign push         = pred_v_i & pred_ready_o;
  assign pop          = res_v_i & ~empty;
  assign head_e       = mem[head];
  assign hit          = (head_e.taken == res_taken_i);
  assign count_o      = count;

  // Payload storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[tail] <= '{idx: pred_idx_i, taken: pred_taken_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + ptr_one_lp;
      if (pop)  head <= head + ptr_one_lp;
      unique case ({push, pop})
        2'b10:   count <= count + cnt_one_lp;
        2'b01:   count <= count - cnt_one_lp;
        default: count <= count;
      endcase
    end
  end

  // Update is registered; a flush still lets the same-cycle resolve through.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
      res_err_o <= 1'b0;
    end else begin
      w_v_o <= pop;
      if (pop) begin
        idx_w_o   <= head_e.idx;
        correct_o <= hit;
      end
      if (res_v_i & empty) res_err_o <= 1'b1;
    end
  end

`ifdef BP_FE_BP_UPDATE_TRACKER_STATS_EN
  logic [31:0] upd_cnt, mis_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      upd_cnt <= '0;
      mis_cnt <= '0;
    end else begin
      if (pop && upd_cnt != '1) upd_cnt <= upd_cnt + 32'd1;
      if (pop && !hit && mis_cnt != '1) mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign update_cnt_o  = upd_cnt;
  assign mispred_cnt_o = mis_cnt;
`else
  assign update_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_tracker.sv
// Directed vector bench for bp_fe_bp_update_tracker (els_p=8, 8-bit index).
module tb_bp_fe_bp_update_tracker;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        pred_v_i;
  logic [7:0]  pred_idx_i;
  logic        pred_taken_i;
  logic        pred_ready_o;
  logic        res_v_i;
  logic        res_taken_i;
  logic        flush_i;
  logic        w_v_o;
  logic [7:0]  idx_w_o;
  logic        correct_o;
  logic [3:0]  count_o;
  logic        res_err_o;
  logic [31:0] mispred_cnt_o;
  logic [31:0] update_cnt_o;

  int checks = 0;
  int errors = 0;

  bp_fe_bp_update_tracker #(.bht_idx_width_p(8), .els_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i),
    .pred_taken_i(pred_taken_i), .pred_ready_o(pred_ready_o),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
    .count_o(count_o), .res_err_o(res_err_o),
    .mispred_cnt_o(mispred_cnt_o), .update_cnt_o(update_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       pv;
    logic [7:0] pidx;
    logic       pt;
    logic       rv;
    logic       rt;
    logic       fl;
    logic       w;
    logic [7:0] widx;
    logic       c;
    logic [3:0] cnt;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic pv, input logic [7:0] pidx,
                     input logic pt, input logic rv, input logic rt,
                     input logic fl);
    pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = pt;
    res_v_i = rv; res_taken_i = rt; flush_i = fl;
    @(posedge clk_i);
    #1;
    pred_v_i = 0; pred_idx_i = '0; pred_taken_i = 0;
    res_v_i = 0; res_taken_i = 0; flush_i = 0;
    #1;
  endtask

  task automatic run_vec(input int i);
    string s;
    cyc(vt[i].pv, vt[i].pidx, vt[i].pt, vt[i].rv, vt[i].rt, vt[i].fl);
    s = $sformatf("v%0d", i);
    chk({s, ".w_v"}, 32'(w_v_o), 32'(vt[i].w));
    chk({s, ".idx_w"}, 32'(idx_w_o), 32'(vt[i].widx));
    chk({s, ".correct"}, 32'(correct_o), 32'(vt[i].c));
    chk({s, ".count"}, 32'(count_o), 32'(vt[i].cnt));
    chk({s, ".ready"}, 32'(pred_ready_o), 32'(vt[i].rdy));
    chk({s, ".res_err"}, 32'(res_err_o), 32'(vt[i].err));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1;
    @(negedge clk_i);
    reset_i = 0;
    @(posedge clk_i);
    #2;
  endtask

  function automatic vec_t mk(input logic pv, input logic [7:0] pidx,
      input logic pt, input logic rv, input logic rt, input logic fl,
      input logic w, input logic [7:0] widx, input logic c,
      input logic [3:0] cnt, input logic rdy, input logic err);
    mk = '{pv, pidx, pt, rv, rt, fl, w, widx, c, cnt, rdy, err};
  endfunction

  logic [31:0] exp_upd, exp_mis;
  logic        exp_c;

  initial begin
`ifdef BP_FE_BP_UPDATE_TRACKER_STATS_EN
    exp_upd = 2; exp_mis = 1;
`else
    exp_upd = 0; exp_mis = 0;
`endif
    //              pv pidx  pt rv rt fl  w  widx  c cnt rdy err
    vt[0]  = mk(1, 8'h12, 1, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    vt[1]  = mk(1, 8'h34, 0, 0, 0, 0, 0, 8'h00, 0, 2, 1, 0);
    vt[2]  = mk(0, 8'h00, 0, 1, 1, 0, 1, 8'h12, 1, 1, 1, 0);
    vt[3]  = mk(0, 8'h00, 0, 1, 1, 0, 1, 8'h34, 0, 0, 1, 0);
    vt[4]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h34, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      vt[5+k] = mk(1, 8'h40 + 8'(k), k[0], 0, 0, 0,
                   0, 8'h34, 0, 4'(k + 1), (k < 7), 0);
    vt[13] = mk(1, 8'h99, 1, 0, 0, 0, 0, 8'h34, 0, 8, 0, 0);
    vt[14] = mk(1, 8'h55, 1, 1, 1, 0, 1, 8'h40, 0, 7, 1, 0);
    vt[15] = mk(0, 8'h00, 0, 1, 0, 0, 1, 8'h41, 0, 6, 1, 0);
    vt[16] = mk(0, 8'h00, 0, 1, 1, 0, 1, 8'h42, 0, 5, 1, 0);
    vt[17] = mk(0, 8'h00, 0, 1, 1, 0, 1, 8'h43, 1, 4, 1, 0);
    vt[18] = mk(0, 8'h00, 0, 1, 1, 0, 1, 8'h44, 0, 3, 1, 0);
    vt[19] = mk(1, 8'h70, 1, 1, 0, 1, 1, 8'h45, 0, 0, 1, 0);
    vt[20] = mk(0, 8'h00, 0, 1, 1, 0, 0, 8'h45, 0, 0, 1, 1);
    vt[21] = mk(1, 8'h88, 1, 0, 0, 0, 0, 8'h45, 0, 1, 1, 1);

    reset_i = 1;
    pred_v_i = 0; pred_idx_i = '0; pred_taken_i = 0;
    res_v_i = 0; res_taken_i = 0; flush_i = 0;
    #3;
    chk("rst.w_v", 32'(w_v_o), 0);
    chk("rst.idx_w", 32'(idx_w_o), 0);
    chk("rst.correct", 32'(correct_o), 0);
    chk("rst.count", 32'(count_o), 0);
    chk("rst.res_err", 32'(res_err_o), 0);
    chk("rst.upd_cnt", update_cnt_o, 0);
    chk("rst.mis_cnt", mispred_cnt_o, 0);
    @(negedge clk_i);
    reset_i = 0;
    @(posedge clk_i);
    #2;
    chk("rst.ready", 32'(pred_ready_o), 1);

    for (int i = 0; i < 5; i++) run_vec(i);
    chk("t1.upd_cnt", update_cnt_o, exp_upd);
    chk("t1.mis_cnt", mispred_cnt_o, exp_mis);
    for (int i = 5; i < 22; i++) run_vec(i);

    // Continuous push+resolve across several pointer wraps.
    do_reset();
    cyc(1, 8'h60, 1, 0, 0, 0);
    chk("wrap.count0", 32'(count_o), 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'h61 + 8'(i), i[0], 1, 1, 0);
      exp_c = (i == 0) ? 1'b1 : 1'((i - 1) % 2);
      chk($sformatf("wrap%0d.w_v", i), 32'(w_v_o), 1);
      chk($sformatf("wrap%0d.idx", i), 32'(idx_w_o), 32'(8'h60 + 8'(i)));
      chk($sformatf("wrap%0d.corr", i), 32'(correct_o), 32'(exp_c));
      chk($sformatf("wrap%0d.count", i), 32'(count_o), 1);
    end
    cyc(0, 8'h00, 0, 1, 1, 0);
    chk("wrap.last_idx", 32'(idx_w_o), 32'h74);
    chk("wrap.last_corr", 32'(correct_o), 1);
    chk("wrap.count_end", 32'(count_o), 0);
    chk("wrap.res_err", 32'(res_err_o), 0);

    // Push and resolve together on an empty queue: no bypass.
    cyc(1, 8'h80, 1, 1, 1, 0);
    chk("emp.w_v", 32'(w_v_o), 0);
    chk("emp.res_err", 32'(res_err_o), 1);
    chk("emp.count", 32'(count_o), 1);

    // Asynchronous reset between edges with an update in flight.
    for (int k = 1; k <= 4; k++) cyc(1, 8'h80 + 8'(k), 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 1, 0);
    chk("ar.pre_w_v", 32'(w_v_o), 1);
    chk("ar.pre_idx", 32'(idx_w_o), 32'h80);
    chk("ar.pre_count", 32'(count_o), 4);
    #1;
    reset_i = 1;
    #1;
    chk("ar.w_v", 32'(w_v_o), 0);
    chk("ar.count", 32'(count_o), 0);
    chk("ar.res_err", 32'(res_err_o), 0);
    chk("ar.upd_cnt", update_cnt_o, 0);
    chk("ar.mis_cnt", mispred_cnt_o, 0);
    @(negedge clk_i);
    reset_i = 0;
    @(posedge clk_i);
    #2;
    chk("ar.ready", 32'(pred_ready_o), 1);
    chk("ar.count_post", 32'(count_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_bp_update_tracker.md
# bp_fe_bp_update_tracker

- Tracks in-flight branch predictions between predictor lookup and backend resolution.
- Queues each issued prediction (BHT index + predicted direction) in program order.
- When the backend resolves the oldest branch, generates the bimodal BHT update (`w_v`/`idx_w`/`correct`).
- Sits in the frontend between the prediction path and the predictor's write port. It is the initiator that drives the predictor's update interface.

## Interface
Parameters:
- `bht_idx_width_p`, 8: BHT index width; must match the predictor.
- `els_p`, 8: queue depth; power of 2, ≥2.
- `ptr_width_lp`, `$clog2(els_p)`: localparam.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `pred_v_i`  in  1  a prediction was issued this cycle.
- `pred_idx_i`  in  `bht_idx_width_p`  BHT index used for the prediction.
- `pred_taken_i`  in  1  predicted direction.
- `pred_ready_o`  out  1  queue can accept; a push occurs only on `pred_v_i & pred_ready_o`.
- `res_v_i`  in  1  oldest outstanding branch resolved this cycle.
- `res_taken_i`  in  1  actual direction.
- `flush_i`  in  1  discard all outstanding predictions.
- `w_v_o`  out  1  predictor update valid.
- `idx_w_o`  out  `bht_idx_width_p`  predictor update index.
- `correct_o`  out  1  1 if the prediction matched the actual direction.
- `count_o`  out  `ptr_width_lp+1`  current occupancy, 0..`els_p`.
- `res_err_o`  out  1  sticky: resolution arrived while the queue was empty.
- `mispred_cnt_o`  out  32  mispredict count (see Configuration).
- `update_cnt_o`  out  32  update count (see Configuration).

## Operation
- Circular buffer with head/tail pointers of `ptr_width_lp` bits, wrapping at `els_p`. The occupancy counter is the source of truth for full/empty.
- `pred_ready_o = (count != els_p) & ~flush_i`. It depends on current occupancy only: a same-cycle pop does not make a full queue ready.
- **Push**: write `{pred_idx_i, pred_taken_i}` at tail; tail+1.
- **Resolve** (`res_v_i` and count≠0):
  - Pop head.
  - Register `w_v_o=1`, `idx_w_o=head.idx`, `correct_o=(head.taken==res_taken_i)`.
- **Resolve with empty queue**: no update, `w_v_o=0`, `res_err_o` set. It stays set until reset.
- **Push and resolve in the same cycle**: both take effect; count unchanged.
- **Push and resolve in the same cycle on an empty queue**: push happens; resolve is an error, with no bypass.
- **Flush**:
  - A resolve in the same cycle is processed first (update emitted).
  - All remaining entries are then discarded: count←0, head←tail.
  - Any same-cycle push is dropped (`pred_ready_o` is already 0).
- `w_v_o` is 1 for exactly one cycle per accepted resolution.
  - `idx_w_o`/`correct_o` hold their last value when `w_v_o=0`.
- Reset values:
  - count, head, tail = 0.
  - `w_v_o=0`, `idx_w_o=0`, `correct_o=0`.
  - `res_err_o=0`, both stat counters 0.
  - `pred_ready_o=1` once reset is deasserted.
- Reset mid-operation: all entries lost immediately (asynchronous); any pending `w_v_o` is cleared.

## Timing
- Push to entry visible for resolve: 1 cycle. A branch pushed in cycle N can be resolved in cycle N+1 at the earliest.
- Resolve to update: 1 cycle. `res_v_i` in cycle N gives `w_v_o` in cycle N+1.
- Sustained throughput: one push and one resolve per cycle.
- `count_o` is registered and reflects pushes/pops from the previous edge.
- `pred_ready_o` is combinational from the count register and `flush_i`.

## Configuration
- Macro: `BP_FE_BP_UPDATE_TRACKER_STATS_EN`.
- Defined:
  - `update_cnt_o` increments on every emitted update.
  - `mispred_cnt_o` increments on every emitted update with `correct_o=0`.
  - Both are 32-bit, saturating at 0xFFFF_FFFF, and cleared by reset.
- Undefined: no counter flops; both ports tied to 0.

## Test plan
- Reset, then push idx 0x12 taken and idx 0x34 not-taken, then resolve taken, taken.
  - Updates in consecutive cycles: (0x12, correct=1), then (0x34, correct=0).
  - `count_o` goes 2→0.
  - Stats build: `update_cnt_o=2`, `mispred_cnt_o=1`.
- Push 8 entries with `els_p=8`.
  - `pred_ready_o=0` and a 9th `pred_v_i` is dropped.
  - A simultaneous push+resolve while full pops one entry only, giving count 7.
- Push and resolve every cycle for 20 cycles (pointer wrap).
  - Updates return indices in push order.
  - Count stays constant.
- Queue holds 3 entries; assert `res_v_i` and `flush_i` together.
  - One update for the head entry.
  - Count 0 next cycle; a following resolve sets `res_err_o`.
- On an empty queue, assert push and resolve in the same cycle.
  - No update, `res_err_o=1`, count=1.
- Assert `reset_i` asynchronously between edges with 4 entries queued and `w_v_o=1`.
  - `w_v_o`, `count_o` and stats go to 0 immediately.
  - `pred_ready_o=1` after release.
